// File: rtl/lsu.sv
// Load/store unit between EXU and DMEM: one operation in flight, 8-byte-aligned
// DMEM accesses with byte-lane masks, load extraction/extension, misalignment reporting.
`timescale 1ns/1ps
module lsu #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misalign,
    output logic              mem_r_EN,
    output logic              mem_w_EN,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, next_state;

    logic              op_wen;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic [1:0]        op_size;
    logic              op_unsigned;

    logic              req_misalign;
    logic [2:0]        offset;
    logic [5:0]        shamt;
    logic [7:0]        mask_base;
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        case (req_size)
            2'd1:    req_misalign = req_addr[0];
            2'd2:    req_misalign = |req_addr[1:0];
            2'd3:    req_misalign = |req_addr[2:0];
            default: req_misalign = 1'b0;
        endcase
    end

    assign offset     = op_addr[2:0];
    assign shamt      = {offset, 3'b000};
    assign mem_addr   = {op_addr[ADDR_W-1:3], 3'b000};
    assign mem_wdata  = op_wdata << shamt;
    assign rd_shifted = mem_rdata >> shamt;

    always_comb begin
        case (op_size)
            2'd0:    mask_base = 8'h01;
            2'd1:    mask_base = 8'h03;
            2'd2:    mask_base = 8'h0F;
            default: mask_base = 8'hFF;
        endcase
    end

    // Byte/half/word loads extend from their top bit unless the op is unsigned.
    always_comb begin
        case (op_size)
            2'd0:    load_data = {{56{rd_shifted[7]  & ~op_unsigned}}, rd_shifted[7:0]};
            2'd1:    load_data = {{48{rd_shifted[15] & ~op_unsigned}}, rd_shifted[15:0]};
            2'd2:    load_data = {{32{rd_shifted[31] & ~op_unsigned}}, rd_shifted[31:0]};
            default: load_data = rd_shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_r_EN   = 1'b0;
        mem_w_EN   = 1'b0;
        mem_wmask  = 8'h00;
        case (state)
            IDLE: begin
                req_ready = ~rst;
                if (req_valid && !rst)
                    next_state = req_misalign ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_r_EN  = ~op_wen;
                mem_w_EN  = op_wen;
                mem_wmask = op_wen ? (mask_base << offset) : 8'h00;
                if (mem_ready)
                    next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wen        <= 1'b0;
            op_addr       <= '0;
            op_wdata      <= '0;
            op_size       <= 2'd0;
            op_unsigned   <= 1'b0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            op_wen        <= req_wen;
            op_addr       <= req_addr;
            op_wdata      <= req_wdata;
            op_size       <= req_size;
            op_unsigned   <= req_unsigned;
            resp_rdata    <= '0;
            resp_misalign <= req_misalign;
        end else if (state == ACCESS && mem_ready) begin
            resp_rdata    <= op_wen ? '0 : load_data;
            resp_misalign <= 1'b0;
        end
    end

endmodule
